alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
//  Round-robin scheduler sharing one alu_top instance among NUM_REQ requesters.
//  Accepts one request at a time and drives operand_a/operand_b/operator/op_valid into the ALU.
//  Waits for operation_done, then returns the result to the owning requester.
//  A timeout aborts the operation if the ALU never completes. Sits between bench/traffic agents and alu_top.
// PARAMETERS
//  NUM_REQ   4    number of requesters (>=2)
//  TIMEOUT   64   max BUSY cycles before abort; 0 = timeout disabled
// PORTS
//  clock           in   1          system clock, rising edge
//  reset           in   1          asynchronous, active-high
//  req_valid       in   NUM_REQ    per-requester request pending
//  req_ready       out  NUM_REQ    one-hot accept; handshake completes when valid&ready
//  req_operand_a   in   NUM_REQ*32 packed, requester i at [32*i+:32]
//  req_operand_b   in   NUM_REQ*32 packed, as above
//  req_operator    in   NUM_REQ*8  packed, requester i at [8*i+:8]
//  rsp_valid       out  NUM_REQ    one-hot, one-cycle response strobe
//  rsp_result      out  32         result, valid with rsp_valid
//  rsp_timeout     out  1          response is a timeout abort, valid with rsp_valid
//  busy            out  1          high in BUSY or RESP state
//  operand_a       out  32         to ALU operand_a
//  operand_b       out  32         to ALU operand_b
//  operator        out  8          to ALU operator
//  op_valid        out  1          to ALU op_valid
//  operation_done  in   1          from ALU
//  result          in   32         from ALU
// BEHAVIOUR
//  Reset: state=IDLE; op_valid, rsp_valid, rsp_timeout, busy = 0.
//   operand_a/b, operator, rsp_result = 0. RR pointer = NUM_REQ-1, so requester 0 has first priority.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//   - req_ready is combinational: one-hot to the winner among asserted req_valid.
//   - Priority order is ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
//   - req_ready = 0 when no req_valid is asserted, and in all other states.
//   - On handshake: register the winner's operands/operator and owner index; ptr <= winner; go BUSY.
//  BUSY:
//   - op_valid = 1 (registered; first asserted the cycle after handshake).
//   - Operands stay stable throughout. Timeout counter starts at 0 and increments each cycle.
//   - operation_done = 1 sampled at an edge: capture result into rsp_result; rsp_timeout <= 0; go RESP.
//   - Otherwise, if TIMEOUT != 0 and the counter reaches TIMEOUT-1: rsp_result <= 0; rsp_timeout <= 1; go RESP.
//   - op_valid is therefore high for at most TIMEOUT cycles. Done on the last cycle wins over timeout.
//  RESP:
//   - op_valid = 0; rsp_valid[owner] = 1 for exactly one cycle; next state IDLE.
//   - The response is not back-pressured.
//  Latency: handshake cycle T; ALU done at the Nth BUSY cycle -> rsp_valid at T+N+1.
//   - Next accept no earlier than T+N+2. Minimum N=1 (done in the first BUSY cycle).
//  operation_done is ignored in IDLE and RESP, with no state change.
//  req_valid that drops before a grant is simply not served. No request is queued internally.
//  Reset mid-operation:
//   - op_valid and rsp_valid drop immediately (asynchronously) and the in-flight operation is dropped with no response.
//   - The pointer returns to NUM_REQ-1.
//  All outputs are registered except req_ready.
// TESTING
//  1 Req1: a=5, b=3, op=8'h01; ALU model done 3 cycles after op_valid, result=8
//    -> req_ready[1] pulse; op_valid high 3 cycles; rsp_valid=4'b0010 one cycle; rsp_result=32'h8; rsp_timeout=0.
//  2 All 4 req_valid held after reset, ALU done in 1 cycle
//    -> grant order 0,1,2,3,0; each accept 3 cycles apart.
//  3 After serving req0, req0 and req2 both valid
//    -> req2 granted first, then req0.
//  4 TIMEOUT=8, ALU never asserts done
//    -> op_valid high exactly 8 cycles; rsp_valid to owner with rsp_timeout=1, rsp_result=0; back to IDLE.
//  5 reset pulsed while BUSY (req3 owner)
//    -> op_valid=0 asynchronously; no rsp_valid[3]; next grant goes to req0 when req0 and req3 are both valid.
//  6 operation_done pulsed while IDLE with no requests
//    -> no rsp_valid, busy stays 0, state IDLE.

Source files
------------

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_scheduler
//  Description : Round-robin scheduler that shares one ALU among NUM_REQ
//                requesters, with per-operation timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_operand_a,
  input  logic [NUM_REQ*32-1:0]  req_operand_b,
  input  logic [NUM_REQ*8-1:0]   req_operator,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_result,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [31:0]            operand_a,
  output logic [31:0]            operand_b,
  output logic [7:0]             operator,
  output logic                   op_valid,
  input  logic                   operation_done,
  input  logic [31:0]            result
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [7:0]         opr_q, opr_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_timeout_q, rsp_timeout_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;

  // Round-robin pick: scan ptr+1, ptr+2, ... and take the first valid requester
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Grant is only offered while idle; it is the sole unregistered output
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    opr_d         = opr_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // ready equals win_found here, so a winner means the handshake fires
        if (win_found) begin
          opa_d   = req_operand_a[32*win_idx +: 32];
          opb_d   = req_operand_b[32*win_idx +: 32];
          opr_d   = req_operator[8*win_idx +: 8];
          owner_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A completion on the final allowed cycle takes precedence over abort
        if (operation_done) begin
          rsp_result_d  = result;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    op_valid_d  = (state_d == ST_BUSY);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = '0;
    if (state_d == ST_RESP) begin
      rsp_valid_d[owner_d] = 1'b1;
    end
  end

  // State and output registers; reset abandons any in-flight operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RST;
      owner_q       <= '0;
      cnt_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      opr_q         <= '0;
      op_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      opr_q         <= opr_d;
      op_valid_q    <= op_valid_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign operator    = opr_q;
  assign op_valid    = op_valid_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_scheduler
//  Description : Self-checking bench for alu_scheduler (NUM_REQ=4, TIMEOUT=8)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_scheduler;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_operand_a;
  logic [NREQ*32-1:0] req_operand_b;
  logic [NREQ*8-1:0] req_operator;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_result;
  logic              rsp_timeout;
  logic              busy;
  logic [31:0]       operand_a;
  logic [31:0]       operand_b;
  logic [7:0]        operator;
  logic              op_valid;
  logic              operation_done;
  logic [31:0]       result;

  int total = 0;
  int bad   = 0;

  // ALU model: done asserted in the alu_lat-th cycle of op_valid
  logic        alu_en;
  int          alu_lat;
  logic [31:0] alu_res;
  logic        done_force;
  int          busy_cyc;

  alu_scheduler #(.NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_operand_a  (req_operand_a),
    .req_operand_b  (req_operand_b),
    .req_operator   (req_operator),
    .rsp_valid      (rsp_valid),
    .rsp_result     (rsp_result),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .operator       (operator),
    .op_valid       (op_valid),
    .operation_done (operation_done),
    .result         (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count cycles of op_valid seen so far (value n-1 during the n-th cycle)
  always @(posedge clock) busy_cyc <= op_valid ? busy_cyc + 1 : 0;

  assign operation_done = done_force | (alu_en & op_valid & (busy_cyc == alu_lat - 1));
  assign result         = alu_res;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    int          lat;
    logic [31:0] res;
    int          grant;
    logic        to;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid  = '0;
    alu_en     = 1'b0;
    alu_lat    = 1;
    done_force = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_op_valid",    op_valid,    0);
    chk("rst_rsp_valid",   rsp_valid,   0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy",        busy,        0);
    chk("rst_operand_a",   operand_a,   0);
    chk("rst_operand_b",   operand_b,   0);
    chk("rst_operator",    operator,    0);
    chk("rst_rsp_result",  rsp_result,  0);
    chk("rst_req_ready",   req_ready,   0);
  endtask

  // One full transaction: grant, BUSY, response, back to IDLE
  task automatic serve(input logic [3:0] vmask, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] op, input int lat, input logic [31:0] res,
                       input int exp_g, input logic exp_to);
    bit got;
    int n;
    got = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_operand_a[32*i +: 32] = (i == exp_g) ? a  : (32'hA5A5_0000 | 32'(i));
      req_operand_b[32*i +: 32] = (i == exp_g) ? b  : (32'h5A5A_0000 | 32'(i));
      req_operator[8*i +: 8]    = (i == exp_g) ? op : (8'hF0 | 8'(i));
    end
    alu_lat   = lat;
    alu_res   = res;
    alu_en    = (lat != 0);
    req_valid = vmask;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready != '0) begin
        got = 1;
        break;
      end
      @(posedge clock);
    end
    chk("grant_seen", 32'(got), 1);
    chk("grant_onehot", req_ready, 4'b1 << exp_g);
    @(posedge clock);
    #1;
    req_valid = vmask & ~(4'b1 << exp_g);
    chk("busy_op_valid",  op_valid,  1);
    chk("busy_operand_a", operand_a, a);
    chk("busy_operand_b", operand_b, b);
    chk("busy_operator",  operator,  op);
    chk("busy_flag",      busy,      1);
    chk("busy_no_ready",  req_ready, 0);
    n = 0;
    while (op_valid && n < 40) begin
      n++;
      @(posedge clock);
      #1;
    end
    chk("op_valid_cycles", n, exp_to ? TO : lat);
    chk("rsp_valid",   rsp_valid,   4'b1 << exp_g);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("rsp_result",  rsp_result,  exp_to ? 32'h0 : res);
    chk("rsp_busy",    busy,        1);
    chk("rsp_no_ready", req_ready,  0);
    @(posedge clock);
    #1;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_busy",      busy,      0);
    req_valid = '0;
    alu_en    = 1'b0;
  endtask

  initial begin
    logic [3:0] g[5];
    int         tc[5];
    int         ng;
    int         seen_rsp;

    req_operand_a = '0;
    req_operand_b = '0;
    req_operator  = '0;
    alu_res       = '0;

    //            mask    a             b             op     lat res            grant to
    tbl[0] = '{4'b0010, 32'd5,        32'd3,        8'h01, 3, 32'h8,        1, 1'b0};
    tbl[1] = '{4'b1000, 32'h1111_0000, 32'h0000_2222, 8'h02, 1, 32'hDEAD_BEEF, 3, 1'b0};
    tbl[2] = '{4'b0001, 32'h7,        32'h9,        8'h03, 8, 32'h1234,     0, 1'b0};
    tbl[3] = '{4'b0100, 32'hFFFF_FFFF, 32'h1,        8'h04, 0, 32'h0,        2, 1'b1};
    tbl[4] = '{4'b0110, 32'h10,       32'h20,       8'h05, 2, 32'h30,       1, 1'b0};
    tbl[5] = '{4'b1111, 32'h44,       32'h55,       8'h06, 4, 32'h99,       2, 1'b0};
    tbl[6] = '{4'b1001, 32'h8000_0000, 32'h8000_0000, 8'h07, 5, 32'hCAFE_F00D, 3, 1'b0};
    tbl[7] = '{4'b0101, 32'h3,        32'h4,        8'h08, 1, 32'h7,        0, 1'b0};
    tbl[8] = '{4'b0001, 32'h6,        32'h2,        8'h09, 9, 32'h55AA,     0, 1'b1};

    // Table-driven single transactions, rotating pointer from its reset value
    do_reset();
    for (int v = 0; v < 9; v++) begin
      serve(tbl[v].mask, tbl[v].a, tbl[v].b, tbl[v].op, tbl[v].lat, tbl[v].res,
            tbl[v].grant, tbl[v].to);
    end

    // All four requesters held: fair rotation, accepts 3 cycles apart
    do_reset();
    alu_en    = 1'b1;
    alu_lat   = 1;
    alu_res   = 32'h1;
    req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 30 && ng < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        g[ng]  = req_ready;
        tc[ng] = c;
        ng++;
      end
      @(posedge clock);
    end
    req_valid = '0;
    chk("rr_grant_count", ng, 5);
    if (ng == 5) begin
      chk("rr_g0", g[0], 4'b0001);
      chk("rr_g1", g[1], 4'b0010);
      chk("rr_g2", g[2], 4'b0100);
      chk("rr_g3", g[3], 4'b1000);
      chk("rr_g4", g[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("rr_spacing", tc[i] - tc[i-1], 3);
    end
    repeat (4) @(posedge clock);
    #1;
    alu_en = 1'b0;

    // After req0 is served, req2 beats a simultaneous req0
    do_reset();
    serve(4'b0001, 32'h1, 32'h2, 8'h11, 2, 32'h3, 0, 1'b0);
    serve(4'b0101, 32'h4, 32'h5, 8'h12, 1, 32'h9, 2, 1'b0);
    serve(4'b0001, 32'h6, 32'h7, 8'h13, 3, 32'hD, 0, 1'b0);

    // Reset while req3 owns the ALU: async drop, no response, pointer restored
    do_reset();
    alu_en    = 1'b0;
    req_valid = 4'b1000;
    #1;
    chk("r5_grant", req_ready, 4'b1000);
    @(posedge clock);
    #1;
    req_valid = '0;
    chk("r5_busy_op_valid", op_valid, 1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("r5_async_op_valid", op_valid, 0);
    chk("r5_async_busy",     busy,     0);
    @(posedge clock);
    #1 reset = 1'b0;
    seen_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      if (rsp_valid != '0) seen_rsp++;
    end
    chk("r5_no_rsp", seen_rsp, 0);
    serve(4'b1001, 32'h21, 32'h22, 8'h23, 2, 32'h43, 0, 1'b0);

    // Stray operation_done while idle is ignored; pointer back at NUM_REQ-1
    do_reset();
    done_force = 1'b1;
    @(posedge clock);
    #1 done_force = 1'b0;
    chk("r6_rsp_valid", rsp_valid, 0);
    chk("r6_busy",      busy,      0);
    chk("r6_op_valid",  op_valid,  0);
    @(posedge clock);
    #1;
    chk("r6_rsp_valid2", rsp_valid, 0);
    chk("r6_busy2",      busy,      0);
    serve(4'b0011, 32'h31, 32'h32, 8'h33, 1, 32'h63, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
